// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue.
// Buffers DEPTH 128-bit I-cache lines (4 instructions each) ahead of the dispatch decoder,
// keeps a single line request to the I-cache in flight, and flushes everything on a
// resolved jump/branch redirect.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   cache_req / cache_addr            line request (held until cache_dout_valid), line address
//   cache_dout / cache_dout_valid     returned line (instr k at bits [32k+31:32k]), 1-cycle pulse
//   jmp_br_valid / jmp_br_addr        redirect pulse and word-aligned target
//   dout / dout_pc / empty            head instruction, its PC, no valid instruction at head
//   rd_en                             dispatch consumes the head instruction this cycle
module instruction_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         cache_req,
  output logic [31:0]  cache_addr,
  input  logic [127:0] cache_dout,
  input  logic         cache_dout_valid,
  input  logic         jmp_br_valid,
  input  logic [31:0]  jmp_br_addr,
  output logic [31:0]  dout,
  output logic [31:0]  dout_pc,
  output logic         empty,
  input  logic         rd_en
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;

  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  logic [1:0]  rd_word_q, rd_word_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] dout_pc_q, dout_pc_d;
  logic        req_q, req_d;
  logic        discard_q, discard_d;

  logic [127:0] mem_q [DEPTH];

  logic outstanding;
  logic busy_after;
  logic do_wr;
  logic do_rd;

  // Same line slot, opposite wrap bit.
  function automatic logic is_full(input ptr_t w, input ptr_t r);
    return (w[AW-1:0] == r[AW-1:0]) && (w[AW] != r[AW]);
  endfunction

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign cache_req  = req_q;
  assign cache_addr = fetch_pc_q;
  assign dout_pc    = dout_pc_q;
  assign dout       = empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]][{rd_word_q, 5'd0} +: 32];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_word_d  = rd_word_q;
    fetch_pc_d = fetch_pc_q;
    dout_pc_d  = dout_pc_q;
    req_d      = req_q;
    discard_d  = discard_q;

    // A request is in flight either visibly (req_q) or as a line we already
    // decided to throw away (discard_q); a return this cycle retires it.
    outstanding = req_q | discard_q;
    busy_after  = outstanding & ~cache_dout_valid;
    do_rd       = rd_en & ~empty & ~jmp_br_valid;
    do_wr       = cache_dout_valid & req_q & ~discard_q & ~jmp_br_valid;

    if (jmp_br_valid) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      rd_word_d  = jmp_br_addr[3:2];
      fetch_pc_d = {jmp_br_addr[31:4], 4'b0000};
      dout_pc_d  = jmp_br_addr;
      // Still waiting on an old line: drop it when it lands, then refetch.
      discard_d  = busy_after;
      req_d      = ~busy_after;
    end else begin
      if (do_rd) begin
        dout_pc_d = dout_pc_q + 32'd4;
        rd_word_d = rd_word_q + 2'd1;
        if (rd_word_q == 2'd3) begin
          rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
      end
      if (do_wr) begin
        wr_ptr_d   = wr_ptr_q + ptr_t'(1);
        fetch_pc_d = fetch_pc_q + 32'd16;
      end
      discard_d = discard_q & ~cache_dout_valid;
      // Fullness is judged on next-state pointers so a same-cycle free makes room.
      req_d     = busy_after ? req_q : ~is_full(wr_ptr_d, rd_ptr_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_word_q  <= 2'd0;
      fetch_pc_q <= {RESET_PC[31:4], 4'b0000};
      dout_pc_q  <= RESET_PC;
      req_q      <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_word_q  <= rd_word_d;
      fetch_pc_q <= fetch_pc_d;
      dout_pc_q  <= dout_pc_d;
      req_q      <= req_d;
      discard_q  <= discard_d;
    end
  end

  // Line storage needs no reset: dout is gated by empty.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= cache_dout;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: a behavioural I-cache plus an instruction-level
// reference model (queue of expected PCs), a short table of cycle vectors, directed
// corner-case sequences and a randomized run.
module tb_instruction_fetch_queue;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cache_req;
  logic [31:0]  cache_addr;
  logic [127:0] cache_dout = '0;
  logic         cache_dout_valid = 1'b0;
  logic         jmp_br_valid = 1'b0;
  logic [31:0]  jmp_br_addr = '0;
  logic [31:0]  dout;
  logic [31:0]  dout_pc;
  logic         empty;
  logic         rd_en = 1'b0;

  instruction_fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cache_req       (cache_req),
    .cache_addr      (cache_addr),
    .cache_dout      (cache_dout),
    .cache_dout_valid(cache_dout_valid),
    .jmp_br_valid    (jmp_br_valid),
    .jmp_br_addr     (jmp_br_addr),
    .dout            (dout),
    .dout_pc         (dout_pc),
    .empty           (empty),
    .rd_en           (rd_en)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Cache model state.
  logic        c_pending;
  logic [31:0] c_addr;
  int unsigned c_cnt;
  int unsigned lat_min, lat_max;
  logic        hold;
  int          n_ret;

  // Reference model: PCs of instructions the queue should currently offer.
  logic [31:0] mq[$];
  logic [31:0] rd_pc;
  logic [31:0] m_fetch;
  logic [1:0]  m_first;
  logic        m_stale;
  int          m_lines;

  typedef struct {
    logic        rd;
    logic        e;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [31:0] f(input logic [31:0] p);
    return p ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [127:0] line_data(input logic [31:0] a);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = f(a + 32'(4 * k));
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    rd_pc     = 32'h0;
    m_fetch   = 32'h0;
    m_first   = 2'd0;
    m_stale   = 1'b0;
    m_lines   = 0;
    c_pending = 1'b0;
    c_cnt     = 0;
    n_ret     = 0;
  endtask

  task automatic check_outputs();
    chk("empty", empty, mq.size() == 0);
    if (mq.size() == 0) begin
      chk("dout_when_empty", dout, 32'h0);
      chk("dout_pc_idle", dout_pc, rd_pc);
    end else begin
      chk("dout_pc", dout_pc, mq[0]);
      chk("dout", dout, f(mq[0]));
    end
    if (cache_req) chk("req_while_full", m_lines < DEPTH, 1);
  endtask

  // Drive one cycle at a negedge, update the model, land on the next negedge and check.
  task automatic tick(input logic rd, input logic jmp, input logic [31:0] ja);
    logic [31:0] p;
    rd_en            = rd;
    jmp_br_valid     = jmp;
    jmp_br_addr      = ja;
    cache_dout_valid = 1'b0;
    if (!c_pending && cache_req && !hold) begin
      c_pending = 1'b1;
      c_addr    = cache_addr;
      c_cnt     = $urandom_range(lat_max, lat_min);
      chk("cache_addr", cache_addr, m_fetch);
    end
    if (c_pending) begin
      if (c_cnt == 0) begin
        cache_dout_valid = 1'b1;
        cache_dout       = line_data(c_addr);
        c_pending        = 1'b0;
        n_ret++;
      end else begin
        c_cnt--;
      end
    end
    if (jmp) begin
      mq.delete();
      m_lines = 0;
      rd_pc   = ja;
      m_fetch = {ja[31:4], 4'b0000};
      m_first = ja[3:2];
      m_stale = c_pending;
    end else begin
      if (rd && mq.size() > 0) begin
        p = mq.pop_front();
        if (p[3:2] == 2'd3) m_lines--;
        rd_pc = p + 32'd4;
      end
      if (cache_dout_valid) begin
        if (m_stale) begin
          m_stale = 1'b0;
        end else begin
          chk("no_overflow", m_lines < DEPTH, 1);
          for (int k = int'(m_first); k < 4; k++) mq.push_back(m_fetch + 32'(4 * k));
          m_first = 2'd0;
          m_lines++;
          m_fetch = m_fetch + 32'd16;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cache_dout_valid = 1'b0;
    jmp_br_valid     = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    rd_en            = 1'b0;
    jmp_br_valid     = 1'b0;
    cache_dout_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_outputs();
  endtask

  initial begin
    int i;
    hold    = 1'b0;
    lat_min = 0;
    lat_max = 0;
    model_reset();

    tbl[0] = '{rd: 1'b0, e: 1'b1, pc: 32'd0,  req: 1'b0, addr: 32'd0};
    tbl[1] = '{rd: 1'b0, e: 1'b1, pc: 32'd0,  req: 1'b1, addr: 32'd0};
    tbl[2] = '{rd: 1'b1, e: 1'b0, pc: 32'd0,  req: 1'b1, addr: 32'd16};
    tbl[3] = '{rd: 1'b1, e: 1'b0, pc: 32'd4,  req: 1'b1, addr: 32'd32};
    tbl[4] = '{rd: 1'b1, e: 1'b0, pc: 32'd8,  req: 1'b1, addr: 32'd48};
    tbl[5] = '{rd: 1'b1, e: 1'b0, pc: 32'd12, req: 1'b0, addr: 32'd0};
    tbl[6] = '{rd: 1'b1, e: 1'b0, pc: 32'd16, req: 1'b1, addr: 32'd64};

    // Reset state and in-order fetch with a one-cycle cache.
    do_reset();
    chk("rst_req", cache_req, 1'b0);
    for (int v = 0; v < 7; v++) begin
      chk("tbl_empty", empty, tbl[v].e);
      chk("tbl_pc", dout_pc, tbl[v].pc);
      chk("tbl_req", cache_req, tbl[v].req);
      if (tbl[v].req) chk("tbl_addr", cache_addr, tbl[v].addr);
      tick(tbl[v].rd, 1'b0, 32'h0);
    end

    // Fill with no reads: exactly DEPTH lines, then one freed entry re-arms the request.
    do_reset();
    repeat (12) tick(1'b0, 1'b0, 32'h0);
    chk("full_req_low", cache_req, 1'b0);
    chk("full_lines", n_ret, DEPTH);
    repeat (4) tick(1'b1, 1'b0, 32'h0);
    chk("refill_req", cache_req, 1'b1);
    chk("refill_addr", cache_addr, 32'd64);
    chk("refill_pc", dout_pc, 32'd16);

    // Redirect to 0x108 while a line is in flight.
    lat_min = 2;
    lat_max = 2;
    do_reset();
    tick(1'b0, 1'b0, 32'h0);
    chk("pre_jmp_req", cache_req, 1'b1);
    tick(1'b0, 1'b1, 32'h108);
    chk("jmp_req_drop", cache_req, 1'b0);
    chk("jmp_pc", dout_pc, 32'h108);
    i = 0;
    while (!cache_req && i < 20) begin tick(1'b0, 1'b0, 32'h0); i++; end
    chk("jmp_req_seen", cache_req, 1'b1);
    chk("jmp_new_addr", cache_addr, 32'h100);
    i = 0;
    while (empty && i < 20) begin tick(1'b0, 1'b0, 32'h0); i++; end
    chk("jmp_first_pc", dout_pc, 32'h108);
    chk("jmp_first_instr", dout, f(32'h108));
    repeat (4) tick(1'b1, 1'b0, 32'h0);

    // Reads while empty must not move anything.
    lat_min = 0;
    lat_max = 0;
    hold    = 1'b1;
    do_reset();
    repeat (3) tick(1'b1, 1'b0, 32'h0);
    chk("emp_rd_empty", empty, 1'b1);
    chk("emp_rd_pc", dout_pc, 32'h0);
    chk("emp_rd_dout", dout, 32'h0);
    hold = 1'b0;
    i = 0;
    while (empty && i < 10) begin tick(1'b0, 1'b0, 32'h0); i++; end
    chk("emp_rd_first_pc", dout_pc, 32'h0);

    // Final-word read of the head and a line return on the same edge.
    do_reset();
    repeat (10) tick(1'b0, 1'b0, 32'h0);
    hold = 1'b1;
    repeat (4) tick(1'b1, 1'b0, 32'h0);
    repeat (3) tick(1'b1, 1'b0, 32'h0);
    chk("same_edge_pre_pc", dout_pc, 32'd28);
    hold = 1'b0;
    tick(1'b1, 1'b0, 32'h0);
    chk("same_edge_pc", dout_pc, 32'd32);
    chk("same_edge_req", cache_req, 1'b1);
    chk("same_edge_addr", cache_addr, 32'd80);
    hold = 1'b1;
    repeat (12) tick(1'b1, 1'b0, 32'h0);
    chk("same_edge_drained", empty, 1'b1);
    chk("same_edge_end_pc", dout_pc, 32'd80);
    hold = 1'b0;

    // Reset pulse mid-request, then a late return that must be ignored.
    lat_min = 5;
    lat_max = 5;
    do_reset();
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", cache_req, 1'b0);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_pc", dout_pc, 32'h0);
    chk("mid_rst_dout", dout, 32'h0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n            = 1'b1;
    cache_dout_valid = 1'b1;
    cache_dout       = {4{32'hBAD0_BAD0}};
    @(posedge clk);
    @(negedge clk);
    cache_dout_valid = 1'b0;
    check_outputs();
    chk("late_ret_req", cache_req, 1'b1);
    chk("late_ret_addr", cache_addr, 32'h0);
    lat_min = 0;
    lat_max = 0;
    repeat (10) tick(1'b1, 1'b0, 32'h0);

    // Randomized traffic against the reference model.
    lat_min = 0;
    lat_max = 3;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic        r;
      logic        j;
      logic [31:0] a;
      r = ($urandom_range(9, 0) < 6);
      j = ($urandom_range(39, 0) == 0);
      a = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      tick(r, j, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
